// File: rtl/ram_1w_nr_init.sv
// ram_1w_nr_init: 1W/NR lane-masked RAM that zeroes itself after reset.
// Define RAM_1W_NR_OUTPUT_REG_EN for an extra rd_data/rd_valid register stage (latency 2).
module ram_1w_nr_init #(
  parameter int WORD_COUNT  = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int MASK_WIDTH  = 4,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             init_busy,
  input  logic                             wr_en,
  input  logic [MASK_WIDTH-1:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [WORD_WIDTH-1:0]            wr_data,
  input  logic [READ_PORTS-1:0]            rd_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]            rd_valid
);
  localparam int LW = WORD_WIDTH / MASK_WIDTH;
  localparam int IW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] mem [WORD_COUNT];
  logic [WORD_WIDTH-1:0] bit_mask, mem_bmask, mem_wdata, rold;
  logic [ADDR_WIDTH-1:0] ra;
  logic [IW-1:0] mem_idx;
  logic mem_we, wr_ok;
  logic [READ_PORTS*WORD_WIDTH-1:0] rdat_q, rdat_d;
  logic [READ_PORTS-1:0] rvld_q, rvld_d;
  assign init_busy = state_q == CLEAR;
  assign wr_ok = wr_en && !init_busy && 32'(wr_addr) < WORD_COUNT;
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) bit_mask[i*LW +: LW] = {LW{wr_mask[i]}};
  end
  always_comb begin
    state_d   = (init_busy && 32'(cnt_q) == WORD_COUNT - 1) ? READY : state_q;
    cnt_d     = init_busy ? cnt_q + 1'b1 : cnt_q;
    mem_we    = init_busy || wr_ok;
    mem_idx   = init_busy ? cnt_q[IW-1:0] : wr_addr[IW-1:0];
    mem_bmask = init_busy ? '1 : bit_mask;
    mem_wdata = init_busy ? '0 : wr_data;
  end
  // Each port sees the merged word on a same-address write when WRITE_FIRST is set.
  always_comb begin
    rdat_d = rdat_q;
    rvld_d = '0;
    ra     = '0;
    rold   = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (!init_busy && rd_en[p]) begin
        ra        = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        rold      = mem[ra[IW-1:0]];
        rvld_d[p] = 1'b1;
        rdat_d[p*WORD_WIDTH +: WORD_WIDTH] = 32'(ra) >= WORD_COUNT ? '0 :
          (WRITE_FIRST != 0 && wr_ok && wr_addr == ra) ? (rold & ~bit_mask) | (wr_data & bit_mask) : rold;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= (mem[mem_idx] & ~mem_bmask) | (mem_wdata & mem_bmask);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdat_q  <= '0;
      rvld_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
    end
  end
`ifdef RAM_1W_NR_OUTPUT_REG_EN
  logic [READ_PORTS*WORD_WIDTH-1:0] rdat2_q;
  logic [READ_PORTS-1:0] rvld2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rdat2_q <= '0;
      rvld2_q <= '0;
    end else begin
      rdat2_q <= rdat_q;
      rvld2_q <= rvld_q;
    end
  end
  assign rd_data  = rdat2_q;
  assign rd_valid = rvld2_q;
`else
  assign rd_data  = rdat_q;
  assign rd_valid = rvld_q;
`endif
endmodule

// File: tb/tb_ram_1w_nr_init.sv
// tb_ram_1w_nr_init: directed checks of clear engine, masked writes, collisions and holds.
module tb_ram_1w_nr_init;
  localparam int AW = 9;
`ifdef RAM_1W_NR_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic init_busy, init_busy0, wr_en;
  logic [3:0] wr_mask;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0] rd_en, rd_valid, rd_valid0;
  logic [2*AW-1:0] rd_addr;
  logic [63:0] rd_data, rd_data0;
  int tests = 0;
  int fails = 0;

  ram_1w_nr_init #(.WORD_COUNT(256), .ADDR_WIDTH(AW), .WORD_WIDTH(32), .MASK_WIDTH(4),
                   .READ_PORTS(2), .WRITE_FIRST(1)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid));
  ram_1w_nr_init #(.WORD_COUNT(256), .ADDR_WIDTH(AW), .WORD_WIDTH(32), .MASK_WIDTH(4),
                   .READ_PORTS(2), .WRITE_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .init_busy(init_busy0), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0));

  typedef struct {
    logic we; logic [3:0] m; logic [AW-1:0] wa; logic [31:0] wd;
    logic [1:0] re; logic [AW-1:0] a0, a1;
    logic [31:0] e0, e1, f0, f1;
  } vec_t;
  vec_t v[16];

  function automatic vec_t mk(logic we, logic [3:0] m, logic [AW-1:0] wa, logic [31:0] wd,
                              logic [1:0] re, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] f0, logic [31:0] f1);
    vec_t r;
    r.we = we; r.m = m; r.wa = wa; r.wd = wd; r.re = re; r.a0 = a0; r.a1 = a1;
    r.e0 = e0; r.e1 = e1; r.f0 = f0; r.f1 = f1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0; wr_mask = 4'h0; wr_addr = '0; wr_data = 32'h0; rd_en = 2'b00; rd_addr = '0;
  endtask

  task automatic req(input logic we, input logic [3:0] m, input logic [AW-1:0] wa,
                     input logic [31:0] wd, input logic [1:0] re,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wr_en = we; wr_mask = m; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = {a1, a0};
    tick;
    idle;
    check("valid_first_cycle", 64'(rd_valid), LAT == 1 ? 64'(re) : 64'h0);
    repeat (LAT - 1) tick;
  endtask

  task automatic clear_run(input int wr_at, output int n, output int vp);
    n = 0;
    vp = 0;
    rd_en = 2'b11;
    rd_addr = {9'd7, 9'd10};
    while (n < 1000) begin
      wr_en = (n == wr_at);
      wr_mask = 4'hF; wr_addr = 9'd10; wr_data = 32'hFFFFFFFF;
      tick;
      n++;
      if (rd_valid != 2'b00 || rd_valid0 != 2'b00) vp++;
      if (!init_busy) break;
    end
    idle;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, vp;
    v[0]  = mk(1'b1, 4'hF, 9'd5,   32'hAABBCCDD, 2'b00, 9'd0,   9'd0,   32'h0, 32'h0, 32'h0, 32'h0);
    v[1]  = mk(1'b1, 4'h5, 9'd5,   32'h11223344, 2'b00, 9'd0,   9'd0,   32'h0, 32'h0, 32'h0, 32'h0);
    v[2]  = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b01, 9'd5,   9'd0,   32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0);
    v[3]  = mk(1'b1, 4'hF, 9'd7,   32'h12345678, 2'b00, 9'd0,   9'd0,   32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0);
    v[4]  = mk(1'b1, 4'h3, 9'd7,   32'hFFFFFFFF, 2'b10, 9'd0,   9'd7,   32'hAA22CC44, 32'h1234FFFF, 32'hAA22CC44, 32'h12345678);
    v[5]  = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b11, 9'd7,   9'd7,   32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF);
    v[6]  = mk(1'b1, 4'hF, 9'd3,   32'h0BADF00D, 2'b00, 9'd0,   9'd0,   32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF);
    v[7]  = mk(1'b1, 4'hF, 9'd200, 32'hCAFEBABE, 2'b01, 9'd3,   9'd0,   32'h0BADF00D, 32'h1234FFFF, 32'h0BADF00D, 32'h1234FFFF);
    v[8]  = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b11, 9'd3,   9'd200, 32'h0BADF00D, 32'hCAFEBABE, 32'h0BADF00D, 32'hCAFEBABE);
    v[9]  = mk(1'b1, 4'h0, 9'd3,   32'hFFFFFFFF, 2'b01, 9'd3,   9'd0,   32'h0BADF00D, 32'hCAFEBABE, 32'h0BADF00D, 32'hCAFEBABE);
    v[10] = mk(1'b1, 4'hF, 9'd300, 32'h55555555, 2'b11, 9'd44,  9'd300, 32'h0, 32'h0, 32'h0, 32'h0);
    v[11] = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b11, 9'd44,  9'd3,   32'h0, 32'h0BADF00D, 32'h0, 32'h0BADF00D);
    v[12] = mk(1'b1, 4'h1, 9'd200, 32'h000000EE, 2'b11, 9'd200, 9'd200, 32'hCAFEBAEE, 32'hCAFEBAEE, 32'hCAFEBABE, 32'hCAFEBABE);
    v[13] = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b10, 9'd0,   9'd200, 32'hCAFEBAEE, 32'hCAFEBAEE, 32'hCAFEBABE, 32'hCAFEBAEE);
    v[14] = mk(1'b1, 4'h8, 9'd255, 32'h7F000000, 2'b01, 9'd255, 9'd0,   32'h7F000000, 32'hCAFEBAEE, 32'h0, 32'hCAFEBAEE);
    v[15] = mk(1'b0, 4'h0, 9'd0,   32'h0,        2'b11, 9'd255, 9'd0,   32'h7F000000, 32'h0, 32'h7F000000, 32'h0);
    idle;
    reset = 1'b1;
    repeat (3) tick;
    check("reset_busy", 64'({init_busy, init_busy0}), 64'h3);
    check("reset_valid", 64'({rd_valid, rd_valid0}), 64'h0);
    check("reset_data", rd_data | rd_data0, 64'h0);
    reset = 1'b0;
    clear_run(0, n, vp);
    check("clear_cycles", 64'(n), 64'd256);
    check("clear_no_valid", 64'(vp), 64'd0);
    check("clear_data_held", rd_data | rd_data0, 64'h0);
    check("clear_busy_both", 64'({init_busy, init_busy0}), 64'h0);
    for (int a = 0; a < 256; a++) begin
      req(1'b0, 4'h0, 9'd0, 32'h0, 2'b11, 9'(a), 9'(255 - a));
      check("sweep_data", rd_data | rd_data0, 64'h0);
      check("sweep_valid", 64'({rd_valid, rd_valid0}), 64'hF);
    end
    for (int i = 0; i < 16; i++) begin
      req(v[i].we, v[i].m, v[i].wa, v[i].wd, v[i].re, v[i].a0, v[i].a1);
      check($sformatf("vec%0d_wf1", i), rd_data, {v[i].e1, v[i].e0});
      check($sformatf("vec%0d_wf0", i), rd_data0, {v[i].f1, v[i].f0});
      check($sformatf("vec%0d_valid", i), 64'({rd_valid, rd_valid0}), 64'({v[i].re, v[i].re}));
    end
    req(1'b0, 4'h0, 9'd0, 32'h0, 2'b11, 9'd3, 9'd200);
    check("multi_port", rd_data, {32'hCAFEBAEE, 32'h0BADF00D});
    for (int k = 0; k < 5; k++) begin
      tick;
      check("hold_data", rd_data, {32'hCAFEBAEE, 32'h0BADF00D});
      check("hold_valid", 64'(rd_valid), 64'h0);
    end
    rd_en = 2'b01; rd_addr = {9'd0, 9'd7};
    tick;
    idle;
    wr_en = 1'b1; wr_mask = 4'hF; wr_addr = 9'd7; wr_data = 32'h0;
    tick;
    idle;
    check("late_write_data", 64'(rd_data[31:0]), 64'h1234FFFF);
    check("late_write_valid", 64'(rd_valid), LAT == 2 ? 64'h1 : 64'h0);
    req(1'b0, 4'h0, 9'd0, 32'h0, 2'b01, 9'd7, 9'd0);
    check("late_write_landed", 64'(rd_data[31:0]), 64'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    repeat (100) tick;
    check("mid_busy", 64'(init_busy), 64'h1);
    reset = 1'b1;
    tick;
    check("mid_reset_data", rd_data | rd_data0, 64'h0);
    reset = 1'b0;
    clear_run(50, n, vp);
    check("restart_cycles", 64'(n), 64'd256);
    check("restart_no_valid", 64'(vp), 64'd0);
    req(1'b0, 4'h0, 9'd0, 32'h0, 2'b11, 9'd10, 9'd200);
    check("clear_wr_ignored", rd_data | rd_data0, 64'h0);
    req(1'b0, 4'h0, 9'd0, 32'h0, 2'b11, 9'd5, 9'd255);
    check("recleared", rd_data | rd_data0, 64'h0);
    check("recleared_valid", 64'({rd_valid, rd_valid0}), 64'hF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
